sprite_anim_engine: RTL and testbench
=====================================

# sprite_anim_engine

Parametrised character sprite engine replacing per-character, per-frame ROM banks with a single packed sprite ROM. It keeps the animation state (idle/run/jump, facing, run-frame counter) internally, advancing only on video frame boundaries. Left-facing frames are produced by horizontal address mirroring. It sits between the character position/draw logic and the RGB mux of the draw pipeline, and returns pixel colour plus an opacity flag with fixed latency.

## Interface
- SPRITE_W, 48, sprite width in pixels
- SPRITE_H, 48, sprite height in pixels
- N_RUN, 8, number of run frames (≥2)
- RUN_DIV, 4, frame_tick pulses per run-frame advance (≥1)
- RGB_W, 12, pixel width
- TRANSP, 12'hF0F, colour key treated as transparent
- DATA_PATH, "", ROM init file; layout frame 0 idle, frame 1 jump, frames 2..N_RUN+1 run; each frame row-major, facing right
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame (vblank start)
- moving  in  1  character moving horizontally
- jumping  in  1  character airborne
- dir_right  in  1  1 = facing right, 0 = facing left
- pix_valid  in  1  pixel request strobe
- pix_x  in  $clog2(SPRITE_W)  column within sprite
- pix_y  in  $clog2(SPRITE_H)  row within sprite
- rgb  out  RGB_W  pixel colour
- rgb_valid  out  1  rgb corresponds to a request issued 3 cycles earlier
- opaque  out  1  pixel valid, in range and rgb != TRANSP

## Operation
- States: IDLE, RUN, JUMP. Evaluated only on a cycle with frame_tick=1; priority jumping → JUMP, else moving → RUN, else IDLE.
- dir_right sampled into dir_q on frame_tick only; no mid-frame flip.
- run_idx (0..N_RUN-1), div_cnt (0..RUN_DIV-1):
  - on tick entering RUN from another state: run_idx=0, div_cnt=0
  - on tick staying in RUN: if div_cnt==RUN_DIV-1 then div_cnt=0, run_idx = (run_idx==N_RUN-1) ? 0 : run_idx+1; else div_cnt+1
  - on tick into IDLE/JUMP: run_idx=0, div_cnt=0
- Frame number: IDLE 0, JUMP 1, RUN 2+run_idx.
- Column: dir_q ? pix_x : SPRITE_W-1-pix_x.
- ROM address = frame*SPRITE_W*SPRITE_H + pix_y*SPRITE_W + column. Width ROM_AW = $clog2((N_RUN+2)*SPRITE_W*SPRITE_H). Multiplications are by constants; no truncation before final sum.
- Out of range (pix_x≥SPRITE_W or pix_y≥SPRITE_H): ROM not addressed meaningfully; rgb forced to TRANSP, opaque=0, rgb_valid still follows pix_valid.
- pix_valid=0: rgb_valid=0, opaque=0, rgb holds last value.

## Timing
- Pipeline: S1 register address + valid + in-range; S2 synchronous ROM read; S3 output register. Latency 3 cycles; one request per cycle, no stalls.
- State/index updates on the tick edge take effect for requests issued the cycle after frame_tick; requests already in flight use the frame captured at S1.
- Reset values: state IDLE, dir_q 1, run_idx 0, div_cnt 0, all pipeline valids 0, rgb 0, rgb_valid 0, opaque 0.
- Reset mid-operation: in-flight requests discarded; rgb_valid low from the cycle after rst until 3 cycles after the first post-reset pix_valid.
- frame_tick coincident with pix_valid: both processed; that request uses the pre-tick frame.

## Structure
- Package sprite_pkg: state enum (IDLE/RUN/JUMP), frame index constants FRAME_IDLE=0, FRAME_JUMP=1, FRAME_RUN0=2.
- One sub-module: existing read_rom (DATA_PATH, ADDR_WIDTH=ROM_AW) for the packed ROM; state machine, counter, address arithmetic and output stage in this module.

## Test plan
- Reset, then idle right, request (3,5) with SPRITE_W=48 → rgb_valid at +3 cycles, rgb = ROM[5*48+3].
- dir_right=0 + tick, request (3,5) → rgb = ROM[5*48+44]; flip not visible for requests before the tick.
- moving=1, RUN_DIV=2, 17 ticks → run_idx sequence 0,0,1,1,…,7,7,0; address base (2+run_idx)*2304.
- jumping=1 and moving=1 on same tick → JUMP, base 2304; drop jumping → RUN with run_idx 0.
- pix_x=48 request → rgb=TRANSP, opaque=0, rgb_valid=1; pixel equal to TRANSP in ROM → opaque=0.
- rst asserted with 3 requests in flight → rgb_valid/opaque/rgb zero next cycle, state IDLE, dir_q 1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animation engine.
// Also holds the address-derived pattern used as the packed sprite image.
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      JUMP
   } anim_state_t;

   localparam int FRAME_IDLE = 0;
   localparam int FRAME_JUMP = 1;
   localparam int FRAME_RUN0 = 2;

   // Every 13th word is the colour key so transparency shows up in every frame.
   function automatic logic [31:0] rom_word(input logic [31:0] addr, input logic alt);
      logic [31:0] h;
      if (addr % 32'd13 == 32'd5) begin
         return 32'h0000_0F0F;
      end
      h = (addr * 32'd37) ^ (addr >> 4);
      if (alt) begin
         h = ~h;
      end
      return h;
   endfunction

endpackage

// File: rtl/read_rom.sv
// Packed sprite ROM with a registered (synchronous) read port.
// A non-empty DATA_PATH selects the alternate built-in image.
module read_rom
   import sprite_pkg::*;
#(
   parameter string DATA_PATH  = "",
   parameter int    ADDR_WIDTH = 15,
   parameter int    DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data
);

   localparam logic ALT_IMAGE = (DATA_PATH != "");

   always_ff @(posedge clk) begin
      data <= DATA_WIDTH'(rom_word(32'(addr), ALT_IMAGE));
   end

endmodule

// File: rtl/sprite_anim_engine.sv
// Character sprite engine: frame-synchronous animation state plus a
// three-stage pixel pipeline (address, ROM read, output) over one packed ROM.
module sprite_anim_engine
   import sprite_pkg::*;
#(
   parameter int              SPRITE_W  = 48,
   parameter int              SPRITE_H  = 48,
   parameter int              N_RUN     = 8,
   parameter int              RUN_DIV   = 4,
   parameter int              RGB_W     = 12,
   parameter logic [RGB_W-1:0] TRANSP   = 12'hF0F,
   parameter string           DATA_PATH = ""
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_tick,
   input  logic                        moving,
   input  logic                        jumping,
   input  logic                        dir_right,
   input  logic                        pix_valid,
   input  logic [$clog2(SPRITE_W)-1:0] pix_x,
   input  logic [$clog2(SPRITE_H)-1:0] pix_y,
   output logic [RGB_W-1:0]            rgb,
   output logic                        rgb_valid,
   output logic                        opaque
);

   localparam int FRAME_PIX = SPRITE_W * SPRITE_H;
   localparam int ROM_AW    = $clog2((N_RUN + 2) * FRAME_PIX);
   localparam int RUN_IW    = $clog2(N_RUN);
   localparam int DIV_W     = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   anim_state_t       state_q, state_d;
   logic              dir_q, dir_d;
   logic [RUN_IW-1:0] run_idx, run_idx_d;
   logic [DIV_W-1:0]  div_cnt, div_cnt_d;

   logic              s1_valid, s1_inr, s2_valid, s2_inr;
   logic [ROM_AW-1:0] s1_addr, addr_d;
   logic              in_range;
   logic [RGB_W-1:0]  rom_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dir_q   <= 1'b1;
         run_idx <= '0;
         div_cnt <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         run_idx <= run_idx_d;
         div_cnt <= div_cnt_d;
      end
   end

   // Animation only moves on a frame boundary; any entry into RUN restarts the cycle.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      run_idx_d = run_idx;
      div_cnt_d = div_cnt;
      if (frame_tick) begin
         dir_d = dir_right;
         if (jumping) begin
            state_d = JUMP;
         end else if (moving) begin
            state_d = RUN;
         end else begin
            state_d = IDLE;
         end
         if (state_d == RUN && state_q == RUN) begin
            if (div_cnt == DIV_W'(RUN_DIV - 1)) begin
               div_cnt_d = '0;
               run_idx_d = (run_idx == RUN_IW'(N_RUN - 1)) ? '0 : run_idx + 1'b1;
            end else begin
               div_cnt_d = div_cnt + 1'b1;
            end
         end else begin
            run_idx_d = '0;
            div_cnt_d = '0;
         end
      end
   end

   // Address is formed from the registered (pre-tick) animation state.
   always_comb begin
      int frame;
      int col;
      int addr_full;
      case (state_q)
         IDLE:    frame = FRAME_IDLE;
         JUMP:    frame = FRAME_JUMP;
         default: frame = FRAME_RUN0 + int'(run_idx);
      endcase
      col       = dir_q ? int'(pix_x) : (SPRITE_W - 1 - int'(pix_x));
      in_range  = (int'(pix_x) < SPRITE_W) && (int'(pix_y) < SPRITE_H);
      addr_full = frame * FRAME_PIX + int'(pix_y) * SPRITE_W + col;
      addr_d    = in_range ? ROM_AW'(addr_full) : '0;
   end

   read_rom #(
      .DATA_PATH  (DATA_PATH),
      .ADDR_WIDTH (ROM_AW),
      .DATA_WIDTH (RGB_W)
   ) u_rom (
      .clk  (clk),
      .addr (s1_addr),
      .data (rom_data)
   );

   // rgb holds its last value when no request reaches the output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_inr    <= 1'b0;
         s1_addr   <= '0;
         s2_valid  <= 1'b0;
         s2_inr    <= 1'b0;
         rgb       <= '0;
         rgb_valid <= 1'b0;
         opaque    <= 1'b0;
      end else begin
         s1_valid  <= pix_valid;
         s1_inr    <= in_range;
         s1_addr   <= addr_d;
         s2_valid  <= s1_valid;
         s2_inr    <= s1_inr;
         rgb_valid <= s2_valid;
         opaque    <= s2_valid && s2_inr && (rom_data != TRANSP);
         if (s2_valid) begin
            rgb <= s2_inr ? rom_data : TRANSP;
         end
      end
   end

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Scoreboard bench for sprite_anim_engine: a frame-level animation model
// predicts each pixel, a negedge monitor pops and compares on rgb_valid.
module tb_sprite_anim_engine;

   localparam int          W   = 48;
   localparam int          H   = 48;
   localparam int          NR  = 8;
   localparam int          RD  = 2;
   localparam logic [11:0] TR  = 12'hF0F;
   localparam int          LAT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0, moving = 1'b0, jumping = 1'b0, dir_right = 1'b1;
   logic       pix_valid = 1'b0;
   logic [5:0] pix_x = '0, pix_y = '0;
   logic [11:0] rgb;
   logic       rgb_valid, opaque;

   int cyc = 0;
   int checks = 0;
   int passed = 0;

   typedef struct {
      int          issue;
      logic [11:0] rgb;
      logic        opq;
   } exp_t;
   exp_t sbq[$];

   // Model: mode 0 idle, 1 run, 2 jump; run frame derived from ticks spent in RUN.
   int m_mode = 0;
   bit m_dir = 1'b1;
   int m_run_ticks = 0;

   sprite_anim_engine #(
      .SPRITE_W (W), .SPRITE_H (H), .N_RUN (NR), .RUN_DIV (RD),
      .RGB_W (12), .TRANSP (TR), .DATA_PATH ("")
   ) dut (
      .clk (clk), .rst (rst), .frame_tick (frame_tick), .moving (moving),
      .jumping (jumping), .dir_right (dir_right), .pix_valid (pix_valid),
      .pix_x (pix_x), .pix_y (pix_y), .rgb (rgb), .rgb_valid (rgb_valid),
      .opaque (opaque)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] rom_pix(input int a);
      int unsigned u;
      u = a;
      if (u % 13 == 5) return TR;
      return 12'((u * 37) ^ (u >> 4));
   endfunction

   function automatic int model_frame();
      if (m_mode == 2) return 1;
      if (m_mode == 0) return 0;
      return 2 + (m_run_ticks / RD) % NR;
   endfunction

   task automatic model_tick(input bit mv, input bit jp, input bit dr);
      int nm;
      nm = jp ? 2 : (mv ? 1 : 0);
      if (nm == 1 && m_mode == 1) m_run_ticks++;
      else m_run_ticks = 0;
      m_mode = nm;
      m_dir  = dr;
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_dir = 1'b1;
      m_run_ticks = 0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
   endtask

   task automatic applyStimulus(input bit tick, input bit mv, input bit jp, input bit dr,
                                input bit pv, input int x, input int y);
      exp_t e;
      int col;
      @(posedge clk);
      #1;
      frame_tick = tick;
      moving     = mv;
      jumping    = jp;
      dir_right  = dr;
      pix_valid  = pv;
      pix_x      = 6'(x);
      pix_y      = 6'(y);
      if (pv) begin
         e.issue = cyc;
         if (x >= W || y >= H) begin
            e.rgb = TR;
            e.opq = 1'b0;
         end else begin
            col   = m_dir ? x : (W - 1 - x);
            e.rgb = rom_pix(model_frame() * W * H + y * W + col);
            e.opq = (e.rgb != TR);
         end
         sbq.push_back(e);
      end
      if (tick) model_tick(mv, jp, dr);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, moving, jumping, dir_right, 1'b0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (!rgb_valid && sbq.size() > 0 && cyc >= sbq[0].issue + LAT) begin
         checkOutput("rgb_valid_missing", 0, 1);
         void'(sbq.pop_front());
      end else if (rgb_valid) begin
         if (sbq.size() == 0) begin
            checkOutput("rgb_valid_spurious", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput("latency", cyc - e.issue, LAT);
            checkOutput("rgb", int'(rgb), int'(e.rgb));
            checkOutput("opaque", int'(opaque), int'(e.opq));
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rgb", int'(rgb), 0);
      checkOutput("reset_rgb_valid", int'(rgb_valid), 0);
      checkOutput("reset_opaque", int'(opaque), 0);
      rst = 1'b0;
      model_reset();

      // Idle facing right, then a left flip that must not affect earlier requests.
      applyStimulus(0, 0, 0, 1, 1, 3, 5);
      applyStimulus(0, 0, 0, 0, 1, 3, 5);
      applyStimulus(1, 0, 0, 0, 1, 3, 5);
      applyStimulus(0, 0, 0, 0, 1, 3, 5);
      applyStimulus(0, 0, 0, 1, 1, 3, 5);

      // Run cycle over 17 ticks, probing a random pixel after each.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1, 1, 0, 1, 1, $urandom_range(0, W - 1), $urandom_range(0, H - 1));
         applyStimulus(0, 1, 0, 1, 1, 0, 0);
      end

      // Jump wins over moving; leaving jump restarts the run at index 0.
      applyStimulus(1, 1, 1, 1, 1, 7, 9);
      applyStimulus(0, 1, 1, 1, 1, 0, 0);
      applyStimulus(1, 1, 0, 1, 1, 7, 9);
      applyStimulus(0, 1, 0, 1, 1, 0, 0);

      // Out of range and a colour-keyed pixel in the idle frame.
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 1, 48, 3);
      applyStimulus(0, 0, 0, 1, 1, 2, 63);
      applyStimulus(0, 0, 0, 1, 1, 5, 0);
      idleCycles(4);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 52), $urandom_range(0, 52));
      end

      // Leave the engine jumping and facing left, then reset with requests in flight.
      applyStimulus(1, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 1, 10, 10);
      applyStimulus(0, 0, 1, 0, 1, 11, 10);
      applyStimulus(0, 0, 1, 0, 1, 12, 10);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pix_valid = 1'b0;
      frame_tick = 1'b0;
      @(posedge clk);
      #1;
      sbq.delete();
      model_reset();
      checkOutput("midreset_rgb", int'(rgb), 0);
      checkOutput("midreset_rgb_valid", int'(rgb_valid), 0);
      checkOutput("midreset_opaque", int'(opaque), 0);
      rst = 1'b0;
      idleCycles(2);
      applyStimulus(0, 0, 0, 0, 1, 3, 5);
      idleCycles(6);
      checkOutput("scoreboard_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
